// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO feeding the UART transmitter via a start/done handshake.
// Define UART_FIFO_AUTO_DRAIN_EN to forward bytes without waiting for a send request.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx_done,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_send,
  input  logic              i_tx_done,
  input  logic              i_clr_ovr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_empty,
  output logic              o_full,
  output logic [DEPTH_LOG2:0] o_count,
  output logic              o_overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  rx_done_q, rx_done_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovr_q, ovr_d;
  logic                  push, pop, push_ok, go;

`ifdef UART_FIFO_AUTO_DRAIN_EN
  logic unused_send;
  assign unused_send = i_send;
  assign go = ~empty_q;
`else
  assign go = i_send & ~empty_q;
`endif

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  always_comb begin
    rx_done_d = i_rx_done;
    push      = i_rx_done & ~rx_done_q;
    pop       = (state_q == S_LOAD);
    push_ok   = push & (~full_q | pop);
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_CNT);
  end

  // Set beats clear so a drop in the clearing cycle is never lost.
  always_comb begin
    ovr_d = ovr_q;
    if (i_clr_ovr)        ovr_d = 1'b0;
    if (push & ~push_ok)  ovr_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = mem_q[rptr_q];
        state_d   = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (i_tx_done) state_d = S_IDLE;
    endcase
    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= i_rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      rx_done_q  <= rx_done_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_count    = cnt_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: cycle table plus hand-written corner sequences.
// Build with UART_FIFO_AUTO_DRAIN_EN to exercise the auto-drain variant.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rx_done, i_send, i_tx_done, i_clr_ovr;
  logic [7:0] i_rx_data;
  logic [7:0] o_tx_data;
  logic       o_tx_start, o_busy, o_empty, o_full, o_overrun;
  logic [4:0] o_count;

  int ncmp = 0;
  int nerr = 0;
  int nstart = 0;
  logic [7:0] last_tx = 8'h00;

  uart_rx_fifo dut (
    .clk(clk), .reset(rst_n),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_send(i_send), .i_tx_done(i_tx_done), .i_clr_ovr(i_clr_ovr),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_tx_start) begin
      nstart  <= nstart + 1;
      last_tx <= o_tx_data;
    end
  end

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       snd;
    logic       txd;
    logic [7:0] e_data;
    logic       e_start;
    logic       e_busy;
    logic       e_empty;
    logic [4:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rx, input logic [7:0] d, input logic snd,
                     input logic txd, input logic [7:0] ed, input logic es,
                     input logic eb, input logic ee, input logic [4:0] ec);
    vec_t v;
    v.rx = rx; v.d = d; v.snd = snd; v.txd = txd;
    v.e_data = ed; v.e_start = es; v.e_busy = eb;
    v.e_empty = ee; v.e_cnt = ec;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    step();
    i_rx_done = 1'b0;
    step();
  endtask

  task automatic get_byte(input logic [7:0] exp, input string name);
    int n0;
    n0 = nstart;
    i_send = 1'b1;
    step();
    i_send = 1'b0;
    step();
    step();
    step();
    chk({name, "_starts"}, nstart - n0, 1);
    chk(name, int'(last_tx), int'(exp));
    chk({name, "_busy"}, int'(o_busy), 1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    chk({name, "_idle"}, int'(o_busy), 0);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cnt"}, int'(o_count), 0);
    chk({p, "_empty"}, int'(o_empty), 1);
    chk({p, "_full"}, int'(o_full), 0);
    chk({p, "_busy"}, int'(o_busy), 0);
    chk({p, "_start"}, int'(o_tx_start), 0);
    chk({p, "_data"}, int'(o_tx_data), 0);
    chk({p, "_ovr"}, int'(o_overrun), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_rx_done = 1'b0; i_rx_data = 8'h00;
    i_send = 1'b0; i_tx_done = 1'b0; i_clr_ovr = 1'b0;
    step();
    step();
    chk_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifdef UART_FIFO_AUTO_DRAIN_EN
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 20 && nstart < 1; i++) step();
    chk("auto_n1", nstart, 1);
    chk("auto_d1", int'(last_tx), 'h11);
    step();
    step();
    step();
    chk("auto_hold", nstart, 1);
    chk("auto_busy", int'(o_busy), 1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    for (int i = 0; i < 20 && nstart < 2; i++) step();
    chk("auto_n2", nstart, 2);
    chk("auto_d2", int'(last_tx), 'h22);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("auto_n_end", nstart, 2);
    chk("auto_empty", int'(o_empty), 1);
    chk("auto_idle", int'(o_busy), 0);
`else
    // rx,d,snd,txd | data,start,busy,empty,cnt
    for (int i = 0; i < 5; i++) add(1, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5'd1);
    for (int i = 0; i < 5; i++) add(1, 8'h3C, 0, 0, 8'h00, 0, 0, 0, 5'd2);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5'd2);
    add(0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 5'd2);
    add(0, 8'h00, 0, 0, 8'hA5, 1, 1, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'hA5, 0, 1, 0, 5'd1);
    add(0, 8'h00, 1, 0, 8'hA5, 0, 1, 0, 5'd1);
    add(0, 8'h00, 0, 1, 8'hA5, 0, 0, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'hA5, 0, 0, 0, 5'd1);
    add(0, 8'h00, 1, 0, 8'hA5, 0, 1, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'h3C, 1, 1, 1, 5'd0);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 1, 1, 5'd0);
    add(0, 8'h00, 0, 1, 8'h3C, 0, 0, 1, 5'd0);
    add(0, 8'h00, 1, 0, 8'h3C, 0, 0, 1, 5'd0);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 0, 1, 5'd0);
    add(0, 8'h00, 0, 1, 8'h3C, 0, 0, 1, 5'd0);
    add(1, 8'h77, 1, 0, 8'h3C, 0, 0, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 5'd1);
    add(0, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 5'd1);

    foreach (tv[k]) begin
      i_rx_done = tv[k].rx;
      i_rx_data = tv[k].d;
      i_send    = tv[k].snd;
      i_tx_done = tv[k].txd;
      step();
      chk($sformatf("tv%0d_data", k), int'(o_tx_data), int'(tv[k].e_data));
      chk($sformatf("tv%0d_start", k), int'(o_tx_start), int'(tv[k].e_start));
      chk($sformatf("tv%0d_busy", k), int'(o_busy), int'(tv[k].e_busy));
      chk($sformatf("tv%0d_empty", k), int'(o_empty), int'(tv[k].e_empty));
      chk($sformatf("tv%0d_cnt", k), int'(o_count), int'(tv[k].e_cnt));
    end
    i_rx_done = 1'b0; i_send = 1'b0; i_tx_done = 1'b0;

    get_byte(8'h77, "drain77");

    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_cnt", int'(o_count), 16);
    chk("fill_full", int'(o_full), 1);
    chk("fill_ovr0", int'(o_overrun), 0);
    push_byte(8'h10);
    chk("drop_cnt", int'(o_count), 16);
    chk("drop_ovr", int'(o_overrun), 1);
    for (int i = 0; i < 16; i++) get_byte(8'(i), $sformatf("wrap%0d", i));
    chk("wrap_empty", int'(o_empty), 1);
    chk("wrap_ovr", int'(o_overrun), 1);
    i_clr_ovr = 1'b1;
    step();
    i_clr_ovr = 1'b0;
    chk("clr_ovr", int'(o_overrun), 0);

    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    chk("f2_full", int'(o_full), 1);
    i_send = 1'b1;
    step();
    i_rx_done = 1'b1;
    i_rx_data = 8'h30;
    i_send = 1'b0;
    step();
    chk("coin_cnt", int'(o_count), 16);
    chk("coin_full", int'(o_full), 1);
    chk("coin_ovr", int'(o_overrun), 0);
    chk("coin_start", int'(o_tx_start), 1);
    chk("coin_data", int'(o_tx_data), 'h20);
    i_rx_done = 1'b0;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    push_byte(8'h31);
    chk("f2_ovr", int'(o_overrun), 1);
    chk("f2_cnt", int'(o_count), 16);
    for (int i = 1; i <= 12; i++)
      get_byte(8'(8'h20 + i), $sformatf("coin%0d", i));

    i_send = 1'b1;
    step();
    i_send = 1'b0;
    step();
    step();
    chk("mid_cnt", int'(o_count), 3);
    chk("mid_busy", int'(o_busy), 1);
    chk("mid_data", int'(o_tx_data), 'h2D);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst1");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_reset_vals("rst2");
    push_byte(8'h55);
    get_byte(8'h55, "post_rst");
    chk("post_empty", int'(o_empty), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
